// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-control types: RAM word and handshake state,
// plus the instruction-arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } imem_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority search: first requester found starting at
// last+1, wrapping modulo CPUS.
module rr_picker #(
  parameter int CPUS = 2,
  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  localparam logic [GW:0] CPUS_W = (GW+1)'(CPUS);

  logic [GW:0]       base;
  logic [GW:0]       sum;
  logic [GW-1:0]     off;
  logic [2*CPUS-1:0] doubled;
  logic [CPUS-1:0]   rotated;

  always_comb begin
    base = {1'b0, last} + (GW+1)'(1);
    if (base >= CPUS_W) begin
      base = '0;
    end
    // rotated[j] corresponds to core (base + j) mod CPUS
    doubled = {req, req};
    rotated = CPUS'(doubled >> base);
    off = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        off = GW'(j);
      end
    end
    sum = base + {1'b0, off};
    if (sum >= CPUS_W) begin
      sum = sum - CPUS_W;
    end
    gnt_idx   = sum[GW-1:0];
    gnt_valid = |req;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-side RAM responder: round-robin among icaches, one-word reads,
// single-cycle iwait release when the word is on iload.
module imem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic                 dbusy,
  output logic                 ramREN,
  output word_t                ramaddr,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 ramerr
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

  imem_arb_state_t state, state_next;
  logic [GW-1:0]   grant, grant_next;
  logic [GW-1:0]   last, last_next;
  word_t           addr_q, addr_next;
  logic            ramerr_next;

  logic [GW-1:0]   pick_idx;
  logic            pick_valid;
  logic            redirect;
  logic            deliver;

  rr_picker #(
    .CPUS (CPUS)
  ) u_picker (
    .req       (iREN),
    .last      (last),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= GW'(CPUS - 1);
      addr_q <= '0;
      ramerr <= 1'b0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      last   <= last_next;
      addr_q <= addr_next;
      ramerr <= ramerr_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    last_next   = last;
    addr_next   = addr_q;
    ramerr_next = ramerr;
    deliver     = 1'b0;
    // A core that dropped its request or moved its PC no longer wants this word
    redirect    = !iREN[grant] || (iaddr[grant] != addr_q);

    case (state)
      IDLE: begin
        if (!dbusy && pick_valid) begin
          grant_next = pick_idx;
          addr_next  = iaddr[pick_idx];
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          state_next = IDLE;
        end else if (ramstate == ACCESS) begin
          deliver    = 1'b1;
          last_next  = grant;
          state_next = IDLE;
        end else if (ramstate == ERROR) begin
          ramerr_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ramREN  = (state == FETCH);
  assign ramaddr = ramREN ? addr_q : '0;

  generate
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_core
      assign iwait[gi] = !(deliver && (grant == GW'(gi)));
      assign iload[gi] = (ramREN && (grant == GW'(gi))) ? ramload : '0;
    end
  endgenerate

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Instruction-side responder for the per-core icache fetch protocol (`iREN`/`iaddr` requests, `iwait`/`iload` replies).
- Sits in memory control between the icaches and the single RAM port.
- Arbitrates round-robin among CPUS cores, issues one-word RAM reads, and releases `iwait` for exactly one cycle when the requested word is on `iload`.
- Defers to the data side whenever `dbusy` is asserted at arbitration time.

## Interface

Parameters:
- CPUS, 2, number of icache requesters.

Ports:
- `CLK`  in  1  system clock, all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `iREN`  in  CPUS  per-core fetch request; held high until served or abandoned.
- `iaddr`  in  CPUS x 32  per-core fetch byte address (`word_t`).
- `iwait`  out  CPUS  per-core stall; low for one cycle = `iload` valid for that core.
- `iload`  out  CPUS x 32  per-core fetch data.
- `dbusy`  in  1  data side owns RAM this cycle; instruction side must not start.
- `ramREN`  out  1  RAM read enable.
- `ramaddr`  out  32  RAM address.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `ramerr`  out  1  sticky; set on any ERROR seen during a fetch, cleared only by reset.

## Operation

States: IDLE, FETCH.
- Registers: `state`, `grant` (log2 CPUS bits), `last` (last served core), `addr_q` (32), `ramerr`.

IDLE:
- `ramREN`=0; all `iwait`=1.
- If `dbusy`=0 and any `iREN` is set:
  - Pick the first requester searching from `last`+1, wrapping modulo CPUS.
  - Latch `grant` and `addr_q` = `iaddr[grant]`.
  - Go to FETCH.
- Otherwise stay in IDLE.

FETCH:
- `ramREN`=1, `ramaddr`=`addr_q`. `dbusy` is ignored; a started fetch runs to completion or abort.
- `ramstate`==ACCESS and request still valid:
  - `iwait[grant]`=0 this cycle, `iload[grant]`=`ramload`.
  - `last`<=`grant`; go to IDLE.
- `iREN[grant]`=0, or `iaddr[grant]`!=`addr_q` (core redirected):
  - Abort. No `iwait` pulse; `last` unchanged; go to IDLE.
  - Abort takes priority over a coincident ACCESS.
- `ramstate`==ERROR:
  - `ramerr`<=1; stay in FETCH and keep `ramREN` asserted (retry).
- BUSY/FREE: stay in FETCH.

Outputs:
- `iload[i]` = `ramload` when `i`==`grant` in FETCH, else 0.
- Non-granted `iwait` = 1 always.
- At most one `iwait` bit is low in any cycle.

Reset (async, `RST`=1):
- `state`=IDLE, `grant`=0, `last`=CPUS-1 (so core 0 wins first), `addr_q`=0, `ramerr`=0.
- Outputs: `iwait`=all 1, `iload`=all 0, `ramREN`=0, `ramaddr`=0.
- Reset mid-FETCH drops `ramREN` immediately, with no `iwait` pulse.

## Timing

- Request seen in IDLE at edge N → FETCH from cycle N+1 with `ramREN`=1.
- Reply in the first cycle `ramstate`==ACCESS, combinationally with `ramload`.
- Minimum latency: request cycle + 1; `iwait` low in cycle 2 if RAM returns ACCESS immediately.
- After a reply, one IDLE cycle always precedes the next grant. Back-to-back fetches from one core are 2 cycles apart minimum.
- Fairness: with all cores requesting continuously, grants rotate 0,1,…,CPUS-1,0; no core waits more than CPUS fetches.
- `dbusy` high in IDLE blocks arbitration for that cycle only; re-evaluated every cycle.

## Structure

- Reuse `word_t` and `ramstate_t` from `cpu_types_pkg`.
- Add `imem_arb_state_t` (IDLE, FETCH) to `cpu_types_pkg`.
- One sub-module `rr_picker`:
  - Parameter CPUS.
  - Inputs `req[CPUS]`, `last`.
  - Outputs `gnt_idx`, `gnt_valid`.
  - Purely combinational rotate-priority search.
- FSM, address latch, output muxing, and `ramerr` live in `imem_arbiter`.

## Test plan

- Reset:
  - Assert `RST` mid-FETCH → `ramREN`=0 and `iwait`=2'b11 in the same cycle.
  - After release, `ramerr`=0 and the first grant goes to core 0.
- Single fetch:
  - Core 0 `iREN`=1, `iaddr`=0x100; RAM answers ACCESS with `ramload`=0xDEADBEEF two cycles after `ramREN`.
  - Expect `ramaddr`=0x100, then one cycle of `iwait[0]`=0 with `iload[0]`=0xDEADBEEF, then IDLE.
- Round-robin:
  - Both cores request continuously at 0x200/0x300 with RAM always ACCESS.
  - Expect grant order 0,1,0,1, with `iwait` pulses every 2 cycles alternating cores.
- Data priority:
  - `dbusy`=1 for 5 cycles while core 1 requests → `ramREN` stays 0 for those 5 cycles.
  - Fetch starts the cycle after `dbusy` falls.
  - `dbusy` rising during FETCH does not drop `ramREN`.
- Abort/redirect:
  - During FETCH, core 0 changes `iaddr` 0x100→0x104 while `ramstate`=ACCESS → no `iwait` pulse.
  - Return to IDLE, then new fetch at 0x104.
  - Same check with `iREN` dropped instead: no pulse, no new fetch.
- Error:
  - `ramstate`=ERROR for 3 cycles then ACCESS → `ramerr`=1 and stays 1.
  - `ramREN` held throughout; a single `iwait` pulse delivers the data.
